matmul_sched: RTL and testbench
===============================

Name: matmul_sched

Overview:
- Loop sequencer for the floating-point matrix-multiply datapath. Walks i (rows of A, M), j (cols of B, N), k (inner, K) and issues operand-pair read addresses to the MAC/dot-product unit with first/last markers.
- Tracks outstanding dot products in a tag FIFO and writes each returned result to its C address.
- Sits between the host start/done interface and the A/B/C operand memories plus the FP MAC.

Parameters:
- MAX_DIM, 100, largest legal value of M, K or N.
- DIM_W, 8, width of the dimension inputs.
- ADDR_W, 14, width of the A/B/C element addresses; must hold MAX_DIM*MAX_DIM-1.
- TAG_DEPTH, 8, tag FIFO depth, i.e. maximum dot products in flight (power of 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle job request; honoured only in IDLE.
- m_val / k_val / n_val  in  DIM_W each  matrix dimensions, sampled on accepted start.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse, also issued on a dimension error.
- err_dim  out  1  sticky; set when a start is rejected for bad dimensions; cleared on next accepted start.
- err_proto  out  1  sticky; set on res_valid while tag FIFO empty; cleared on next accepted start.
- op_valid  out  1  operand beat valid.
- op_ready  in  1  MAC accepts beat when op_valid&&op_ready.
- a_addr  out  ADDR_W  row-major A index, i*K+k.
- b_addr  out  ADDR_W  row-major B index, k*N+j.
- op_first  out  1  beat has k==0.
- op_last  out  1  beat has k==K-1.
- res_valid  in  1  MAC result strobe, one per op_last beat, returned in issue order.
- res_data  in  32  IEEE-754 single result.
- c_we  out  1  C write enable.
- c_addr  out  ADDR_W  C index, i*N+j.
- c_wdata  out  32  C data.

Behaviour:
- Reset: state IDLE; busy, done, op_valid, c_we, err_dim and err_proto are 0; all addresses and c_wdata are 0; tag FIFO is emptied.
- Reset mid-job aborts the job with no done pulse.
- FSM states:
  - IDLE: on start, latch dims.
    - Any dim == 0 or > MAX_DIM: go to DONE with err_dim set.
    - Otherwise go to ISSUE. start is ignored while busy.
  - ISSUE: drive beats; advance on a handshake.
  - DRAIN: all beats issued; wait for tag FIFO empty.
  - DONE: done=1 for one cycle, then IDLE.
- Issue order: k innermost, then j, then i. Total beats M*N*K.
- ISSUE exits to DRAIN on the handshake of the final beat (i=M-1, j=N-1, k=K-1).
- Address generation is incremental; there are no multipliers.
  - a_addr = row_base + k; row_base += K at each new i.
  - b_addr starts at j and increments by N per k.
  - c tag = i*N+j, incremented by 1 per dot product.
- op_valid/a_addr/b_addr/op_first/op_last are registered. They hold stable while op_valid && !op_ready.
- The next beat is presented in the cycle after a handshake, so a continuously ready MAC sees back-to-back beats.
- Tag FIFO:
  - Push of the c tag on the handshake of each op_last beat.
  - op_valid is held low when the registered FIFO count == TAG_DEPTH and the pending beat has op_first=1. This gates at dot-product granularity.
  - A pop in the same cycle does not release the stall until the next cycle.
- Result path:
  - On res_valid with FIFO non-empty: pop, then next cycle c_we=1, c_addr=popped tag, c_wdata=res_data.
  - res_valid with FIFO empty: result dropped, err_proto set.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Latency: first beat appears 1 cycle after an accepted start. done asserts 1 cycle after the last c_we when the FIFO drains.
- Degenerate K==1: every beat has op_first=op_last=1.

Optional Feature:
- MATMUL_SCHED_PERF_EN, when defined, adds two 32-bit outputs:
  - perf_cycles: cycles spent in ISSUE+DRAIN.
  - perf_stalls: cycles with op_valid&&!op_ready, or with issue blocked by a full FIFO.
  - Both clear on an accepted start and saturate at all-ones.
- When undefined, these ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package matmul_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE).
  - DIM_W and ADDR_W defaults.
  - MAX_DIM constant.
  - FP32 width constant.
- One sub-module: matmul_tag_fifo, a synchronous FIFO of ADDR_W tags with registered count, full and empty.

Test Plan:
- M=K=N=2, op_ready=1, 3-cycle fixed result latency -> (a,b) beats (0,0)(1,2)(0,1)(1,3)(2,0)(3,2)(2,1)(3,3); op_last on beats 2,4,6,8; c_we addresses 0,1,2,3 in order; single done; busy low afterwards.
- M=1,K=1,N=1 -> one beat with a=0, b=0, first=last=1; one c_we to address 0 carrying res_data unchanged.
- start with k_val=0, then m_val=101 -> done pulse 1 cycle later, err_dim=1, no op_valid, no c_we. A following valid start clears err_dim.
- M=K=N=3, op_ready random 50% -> address sequence identical to the ready-always run; beats never change while stalled; 27 handshakes; 9 writes.
- TAG_DEPTH=8, M=1, N=20, K=1, result latency 30 cycles -> op_valid held low after 8 issued dot products until the first result pops; all 20 C addresses 0..19 written in order.
- Reset asserted mid-ISSUE in a 4x4x4 job -> next cycle busy=0, op_valid=0, FIFO empty, no done. A new 2x2x2 start then completes correctly; a spurious res_valid in IDLE sets err_proto.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply loop sequencer.
package matmul_pkg;

    localparam int unsigned DEF_MAX_DIM   = 100;
    localparam int unsigned DEF_DIM_W     = 8;
    localparam int unsigned DEF_ADDR_W    = 14;
    localparam int unsigned DEF_TAG_DEPTH = 8;
    localparam int unsigned FP_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/matmul_tag_fifo.sv
// Synchronous FIFO of C-address tags for in-flight dot products; registered count/full/empty.
module matmul_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 14,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_c;

    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        count_c   = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_c;
            full  <= (count_c == CNT_W'(DEPTH));
            empty <= (count_c == '0);
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Matrix-multiply loop sequencer: walks i/j/k issuing A/B operand beats, writes MAC results to C.
// Define MATMUL_SCHED_PERF_EN to add the perf_cycles/perf_stalls counters.
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int unsigned MAX_DIM   = DEF_MAX_DIM,
    parameter int unsigned DIM_W     = DEF_DIM_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m_val,
    input  logic [DIM_W-1:0]  k_val,
    input  logic [DIM_W-1:0]  n_val,
    output logic              busy,
    output logic              done,
    output logic              err_dim,
    output logic              err_proto,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              op_first,
    output logic              op_last,
    input  logic              res_valid,
    input  logic [FP_W-1:0]   res_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [FP_W-1:0]   c_wdata
`ifdef MATMUL_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    state_t            state;
    state_t            state_d;
    logic [DIM_W-1:0]  k_r, n_r, m_last, k_last, n_last;
    logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] c_tag;
    logic [ADDR_W-1:0] tag_head;
    logic [CNT_W-1:0]  tag_count;
    logic              tag_full;
    logic              tag_empty;

    logic dim_bad_c, start_acc_c, start_ok_c, hs_c, push_c, final_c, pop_c;
    logic next_first_c, block_c;

    // A dot-product start is blocked if the FIFO is, or is about to become, full.
    always_comb begin
        dim_bad_c    = (m_val == '0) || (k_val == '0) || (n_val == '0) ||
                       (m_val > DIM_W'(MAX_DIM)) || (k_val > DIM_W'(MAX_DIM)) ||
                       (n_val > DIM_W'(MAX_DIM));
        start_acc_c  = (state == ST_IDLE) && start;
        start_ok_c   = start_acc_c && !dim_bad_c;
        hs_c         = op_valid && op_ready;
        push_c       = hs_c && op_last;
        final_c      = push_c && (i_cnt == m_last) && (j_cnt == n_last);
        pop_c        = res_valid && !tag_empty;
        next_first_c = hs_c ? op_last : op_first;
        block_c      = next_first_c &&
                       (tag_full || ((tag_count == CNT_W'(TAG_DEPTH - 1)) && push_c && !pop_c));

        state_d = state;
        case (state)
            ST_IDLE:  if (start_acc_c) state_d = dim_bad_c ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (final_c)     state_d = ST_DRAIN;
            ST_DRAIN: if (tag_empty)   state_d = ST_DONE;
            ST_DONE:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err_dim   <= 1'b0;
            err_proto <= 1'b0;
            op_valid  <= 1'b0;
            op_first  <= 1'b0;
            op_last   <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            c_wdata   <= '0;
            k_r       <= '0;
            n_r       <= '0;
            m_last    <= '0;
            k_last    <= '0;
            n_last    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            row_base  <= '0;
            c_tag     <= '0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= (state_d == ST_DONE);
            if (start_acc_c) err_dim <= dim_bad_c;
            if (start_ok_c)  err_proto <= 1'b0;
            if (res_valid && tag_empty) err_proto <= 1'b1;

            if (start_ok_c) begin
                k_r      <= k_val;
                n_r      <= n_val;
                m_last   <= m_val - DIM_W'(1);
                k_last   <= k_val - DIM_W'(1);
                n_last   <= n_val - DIM_W'(1);
                i_cnt    <= '0;
                j_cnt    <= '0;
                k_cnt    <= '0;
                row_base <= '0;
                c_tag    <= '0;
                a_addr   <= '0;
                b_addr   <= '0;
                op_first <= 1'b1;
                op_last  <= (k_val == DIM_W'(1));
                op_valid <= 1'b1;
            end else if (state == ST_ISSUE) begin
                if (hs_c) begin
                    if (final_c) begin
                        op_valid <= 1'b0;
                    end else begin
                        op_valid <= !block_c;
                        if (op_last) begin
                            k_cnt    <= '0;
                            op_first <= 1'b1;
                            op_last  <= (k_last == '0);
                            c_tag    <= c_tag + ADDR_W'(1);
                            if (j_cnt == n_last) begin
                                j_cnt    <= '0;
                                i_cnt    <= i_cnt + DIM_W'(1);
                                row_base <= row_base + ADDR_W'(k_r);
                                a_addr   <= row_base + ADDR_W'(k_r);
                                b_addr   <= '0;
                            end else begin
                                j_cnt  <= j_cnt + DIM_W'(1);
                                a_addr <= row_base;
                                b_addr <= ADDR_W'(j_cnt) + ADDR_W'(1);
                            end
                        end else begin
                            k_cnt    <= k_cnt + DIM_W'(1);
                            a_addr   <= a_addr + ADDR_W'(1);
                            b_addr   <= b_addr + ADDR_W'(n_r);
                            op_first <= 1'b0;
                            op_last  <= ((k_cnt + DIM_W'(1)) == k_last);
                        end
                    end
                end else if (!op_valid) begin
                    op_valid <= !block_c;
                end
            end

            c_we <= pop_c;
            if (pop_c) begin
                c_addr  <= tag_head;
                c_wdata <= res_data;
            end
        end
    end

    matmul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ADDR_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (c_tag),
        .pop       (pop_c),
        .pop_data  (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

`ifdef MATMUL_SCHED_PERF_EN
    logic stall_c;
    assign stall_c = (op_valid && !op_ready) ||
                     ((state == ST_ISSUE) && !op_valid && op_first && tag_full);

    // Saturating job counters, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_ok_c) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (((state == ST_ISSUE) || (state == ST_DRAIN)) && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if (stall_c && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: randomized jobs, a loop-nest reference model and a scoreboard monitor.
module tb_matmul_sched;
    import matmul_pkg::*;

    localparam int unsigned DIM_W  = DEF_DIM_W;
    localparam int unsigned ADDR_W = DEF_ADDR_W;
    localparam int unsigned DEPTH  = DEF_TAG_DEPTH;
    localparam int unsigned BW     = 2 * ADDR_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  m_val = '0, k_val = '0, n_val = '0;
    logic              op_ready = 1'b0;
    logic              res_valid = 1'b0;
    logic [31:0]       res_data = '0;
    logic              busy, done, err_dim, err_proto, op_valid, op_first, op_last, c_we;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic [31:0]       c_wdata;

    matmul_sched dut (
        .clk(clk), .rst(rst), .start(start), .m_val(m_val), .k_val(k_val), .n_val(n_val),
        .busy(busy), .done(done), .err_dim(err_dim), .err_proto(err_proto),
        .op_valid(op_valid), .op_ready(op_ready), .a_addr(a_addr), .b_addr(b_addr),
        .op_first(op_first), .op_last(op_last), .res_valid(res_valid), .res_data(res_data),
        .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    int hs_cnt = 0, we_cnt = 0, done_cnt = 0, ov_cnt = 0;
    int inflight = 0, max_inflight = 0, last_we_cyc = 0;
    int lat = 3, rdy_pct = 100;
    bit expect_drain = 1'b0, spur_req = 1'b0, stall_prev = 1'b0;
    logic [BW-1:0] stall_beat;

    logic [BW-1:0] exp_beats[$];
    int            exp_caddr[$];
    logic [31:0]   exp_cdata[$];
    int            due_q[$];
    logic [31:0]   pdata_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // MAC model: random ready, fixed-latency in-order results, optional spurious strobe.
    always @(negedge clk) begin
        if (rst) begin
            due_q.delete();
            pdata_q.delete();
            op_ready  = 1'b0;
            res_valid = 1'b0;
        end else begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                due_q.delete(0);
                res_data  = pdata_q.pop_front();
                res_valid = 1'b1;
                exp_cdata.push_back(res_data);
            end else if (spur_req) begin
                res_valid = 1'b1;
                res_data  = 32'hdead_beef;
                spur_req  = 1'b0;
            end else begin
                res_valid = 1'b0;
            end
            op_ready = (int'($urandom_range(99)) < rdy_pct);
            if (op_valid && op_ready && op_last) begin
                due_q.push_back(cyc + lat);
                pdata_q.push_back($urandom);
            end
        end
    end

    // Monitor: compares beats and C writes against the scoreboard queues.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            inflight   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'({op_valid, a_addr, b_addr, op_first, op_last}),
                      64'({1'b1, stall_beat}));
            if (op_valid) ov_cnt++;
            if (op_valid && op_first)
                check("fifo_gate", 64'(inflight < int'(DEPTH)), 64'(1));
            if (op_valid && op_ready) begin
                hs_cnt++;
                if (exp_beats.size() == 0)
                    check("beat_unexpected", 64'({a_addr, b_addr, op_first, op_last}), 64'(0));
                else
                    check("beat", 64'({a_addr, b_addr, op_first, op_last}), 64'(exp_beats.pop_front()));
                if (op_last) inflight++;
            end
            stall_prev = op_valid && !op_ready;
            stall_beat = {a_addr, b_addr, op_first, op_last};
            if (res_valid && inflight > 0) inflight--;
            if (inflight > max_inflight) max_inflight = inflight;
            if (c_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                if (exp_caddr.size() == 0 || exp_cdata.size() == 0)
                    check("write_unexpected", 64'(c_addr), 64'(0));
                else begin
                    check("c_addr", 64'(c_addr), 64'(exp_caddr.pop_front()));
                    check("c_wdata", 64'(c_wdata), 64'(exp_cdata.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_with_done", 64'(busy), 64'(1));
                if (expect_drain) check("done_after_last_write", 64'(cyc - last_we_cyc), 64'(1));
            end
        end
    end

    task automatic start_job(input int m, input int k, input int n, input int lat_i, input int rdy_i);
        lat = lat_i;
        rdy_pct = rdy_i;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                for (int kk = 0; kk < k; kk++)
                    exp_beats.push_back({ADDR_W'(i * k + kk), ADDR_W'(kk * n + j),
                                         1'(kk == 0), 1'(kk == k - 1)});
                exp_caddr.push_back(i * n + j);
            end
        end
        max_inflight = 0;
        @(negedge clk);
        m_val = DIM_W'(m); k_val = DIM_W'(k); n_val = DIM_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("busy_on_start", 64'(busy), 64'(1));
        check("first_beat_latency", 64'(op_valid), 64'(1));
        check("err_dim_cleared", 64'(err_dim), 64'(0));
    endtask

    task automatic run_job(input int m, input int k, input int n, input int lat_i, input int rdy_i);
        int hs0, we0, d0, budget;
        hs0 = hs_cnt; we0 = we_cnt; d0 = done_cnt;
        budget = m * n * k * 20 + m * n * lat_i + 200;
        expect_drain = 1'b1;
        start_job(m, k, n, lat_i, rdy_i);
        for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        check("done_count", 64'(done_cnt - d0), 64'(1));
        check("busy_idle", 64'(busy), 64'(0));
        check("handshakes", 64'(hs_cnt - hs0), 64'(m * n * k));
        check("writes", 64'(we_cnt - we0), 64'(m * n));
        check("beats_left", 64'(exp_beats.size()), 64'(0));
        check("caddr_left", 64'(exp_caddr.size()), 64'(0));
        expect_drain = 1'b0;
    endtask

    task automatic bad_start(input int m, input int k, input int n);
        int d0, ov0, we0;
        d0 = done_cnt; ov0 = ov_cnt; we0 = we_cnt;
        @(negedge clk);
        m_val = DIM_W'(m); k_val = DIM_W'(k); n_val = DIM_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("err_done_pulse", 64'(done), 64'(1));
        check("err_dim_set", 64'(err_dim), 64'(1));
        repeat (3) @(negedge clk);
        #2;
        check("err_no_beats", 64'(ov_cnt - ov0), 64'(0));
        check("err_no_writes", 64'(we_cnt - we0), 64'(0));
        check("err_single_done", 64'(done_cnt - d0), 64'(1));
        check("err_dim_sticky", 64'({busy, err_dim}), 64'(2'b01));
    endtask

    initial begin
        int d0, we0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_flags", 64'({busy, done, op_valid, c_we, err_dim, err_proto}), 64'(0));
        check("rst_addrs", 64'({a_addr, b_addr, c_addr}), 64'(0));
        check("rst_wdata", 64'(c_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_job(2, 2, 2, 3, 100);
        run_job(1, 1, 1, 2, 100);
        bad_start(2, 0, 2);
        bad_start(101, 2, 2);
        run_job(1, 2, 1, 2, 100);
        run_job(3, 3, 3, 4, 50);
        run_job(1, 1, 20, 30, 100);
        check("fifo_depth_reached", 64'(max_inflight), 64'(DEPTH));
        for (int r = 0; r < 6; r++)
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 10)), int'($urandom_range(30, 100)));

        // Abort a 4x4x4 job mid-issue.
        start_job(4, 4, 4, 5, 100);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        exp_beats.delete();
        exp_caddr.delete();
        exp_cdata.delete();
        d0 = done_cnt;
        @(negedge clk);
        #2;
        check("abort_idle", 64'({busy, op_valid, done, c_we}), 64'(0));
        repeat (5) @(negedge clk);
        #2;
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        check("abort_no_proto", 64'(err_proto), 64'(0));
        run_job(2, 2, 2, 3, 100);
        check("proto_clear", 64'(err_proto), 64'(0));

        we0 = we_cnt;
        @(negedge clk);
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("spurious_err_proto", 64'(err_proto), 64'(1));
        check("spurious_no_write", 64'(we_cnt - we0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
